// File: rtl/cpu_phase_sequencer.sv
// Five-phase CPU instruction sequencer: one-hot FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// phase register with start, halt, single-step, stall, memory-skip and retire counting.
module cpu_phase_sequencer #(
  parameter bit          SkipMemory = 1'b1,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ClockEnable,
  input  logic                  Run,
  input  logic                  Halt,
  input  logic                  Stall,
  input  logic                  MemRequired,
  output logic                  Phase_Fetch,
  output logic                  Phase_Decode,
  output logic                  Phase_Execute,
  output logic                  Phase_Memory,
  output logic                  Phase_Writeback,
  output logic                  Busy,
  output logic                  InstrDone,
  output logic [CountWidth-1:0] InstrCount
);

  localparam int unsigned NumPhases = 5;

  // State register is the phase vector itself; IDLE is all-zero.
  typedef enum logic [NumPhases-1:0] {
    ST_IDLE      = 5'b00000,
    ST_FETCH     = 5'b00001,
    ST_DECODE    = 5'b00010,
    ST_EXECUTE   = 5'b00100,
    ST_MEMORY    = 5'b01000,
    ST_WRITEBACK = 5'b10000
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic                  halt_pending_q;
  logic                  halt_pending_d;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;

  // State, pending-halt and retire counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      halt_pending_q <= 1'b0;
      count_q        <= '0;
    end else if (ClockEnable) begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      count_q        <= count_d;
    end
  end

  // Next-state, pending-halt and counter update.
  always_comb begin
    state_d        = state_q;
    halt_pending_d = halt_pending_q;
    count_d        = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!Stall) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (MemRequired || !SkipMemory) state_d = ST_MEMORY;
        else                            state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (!Stall) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        count_d = count_q + CountWidth'(1);
        if (halt_pending_q || Halt) state_d = ST_IDLE;
        else                        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A halt seen on any edge that leaves or stays out of IDLE is remembered
    // until the sequencer next enters IDLE (covers the Run+Halt single step).
    if (state_d == ST_IDLE) halt_pending_d = 1'b0;
    else if (Halt)          halt_pending_d = 1'b1;
  end

  // Outputs are taken straight from the registered phase vector and counter.
  always_comb begin
    Phase_Fetch     = state_q[0];
    Phase_Decode    = state_q[1];
    Phase_Execute   = state_q[2];
    Phase_Memory    = state_q[3];
    Phase_Writeback = state_q[4];
    Busy            = |state_q;
    InstrDone       = state_q[4];
    InstrCount      = count_q;
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer: two instances (skip/16-bit, no-skip/4-bit)
// driven by shared directed + random stimulus and checked against a phase-level model.
module tb_cpu_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic run = 1'b0;
  logic halt = 1'b0;
  logic stall = 1'b0;
  logic memreq = 1'b0;

  logic pf_a, pd_a, pe_a, pm_a, pw_a, busy_a, done_a;
  logic pf_b, pd_b, pe_b, pm_b, pw_b, busy_b, done_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  cpu_phase_sequencer #(.SkipMemory(1'b1), .CountWidth(16)) dut_a (
    .Clock(clk), .Reset(rst), .ClockEnable(ce), .Run(run), .Halt(halt),
    .Stall(stall), .MemRequired(memreq),
    .Phase_Fetch(pf_a), .Phase_Decode(pd_a), .Phase_Execute(pe_a),
    .Phase_Memory(pm_a), .Phase_Writeback(pw_a), .Busy(busy_a),
    .InstrDone(done_a), .InstrCount(cnt_a)
  );

  cpu_phase_sequencer #(.SkipMemory(1'b0), .CountWidth(4)) dut_b (
    .Clock(clk), .Reset(rst), .ClockEnable(ce), .Run(run), .Halt(halt),
    .Stall(stall), .MemRequired(memreq),
    .Phase_Fetch(pf_b), .Phase_Decode(pd_b), .Phase_Execute(pe_b),
    .Phase_Memory(pm_b), .Phase_Writeback(pw_b), .Busy(busy_b),
    .InstrDone(done_b), .InstrCount(cnt_b)
  );

  typedef struct {
    int          due;
    logic [4:0]  ph_a;
    logic [4:0]  ph_b;
    logic        busy_a;
    logic        busy_b;
    logic        done_a;
    logic        done_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) edge_n++;

  // Reference model: where each instance is within its instruction, by name.
  localparam int IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEMORY = 4, WRITEBACK = 5;
  int          where [2];
  bit          stop_req [2];
  int unsigned retired [2];
  bit          skip_mem [2];

  function automatic logic [4:0] phase_vec(int p);
    logic [4:0] v;
    v = '0;
    if (p != IDLE) v[p-1] = 1'b1;
    return v;
  endfunction

  task automatic model_step(int i);
    int nxt;
    if (rst) begin
      where[i] = IDLE; stop_req[i] = 0; retired[i] = 0;
      return;
    end
    if (!ce) return;
    nxt = where[i];
    case (where[i])
      IDLE:      if (run) nxt = FETCH;
      FETCH:     if (!stall) nxt = DECODE;
      DECODE:    nxt = EXECUTE;
      EXECUTE:   nxt = (memreq || !skip_mem[i]) ? MEMORY : WRITEBACK;
      MEMORY:    if (!stall) nxt = WRITEBACK;
      WRITEBACK: begin
        retired[i]++;
        nxt = (stop_req[i] || halt) ? IDLE : FETCH;
      end
      default:   nxt = IDLE;
    endcase
    if (nxt == IDLE) stop_req[i] = 0;
    else if (halt)   stop_req[i] = 1;
    where[i] = nxt;
  endtask

  // Apply one cycle of inputs and queue what both instances must show after the edge.
  task automatic drive(bit r, bit c, bit rn, bit h, bit s, bit m);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ce = c; run = rn; halt = h; stall = s; memreq = m;
    model_step(0);
    model_step(1);
    e.due    = edge_n + 1;
    e.ph_a   = phase_vec(where[0]);
    e.ph_b   = phase_vec(where[1]);
    e.busy_a = (where[0] != IDLE);
    e.busy_b = (where[1] != IDLE);
    e.done_a = (where[0] == WRITEBACK);
    e.done_b = (where[1] == WRITEBACK);
    e.cnt_a  = 16'(retired[0] % 65536);
    e.cnt_b  = 4'(retired[1] % 16);
    q.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Monitor: pop every expectation that is due and compare against the DUT.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= edge_n) begin
      e = q.pop_front();
      check("phase_a", 32'({pw_a, pm_a, pe_a, pd_a, pf_a}), 32'(e.ph_a));
      check("busy_a",  32'(busy_a), 32'(e.busy_a));
      check("done_a",  32'(done_a), 32'(e.done_a));
      check("count_a", 32'(cnt_a),  32'(e.cnt_a));
      check("phase_b", 32'({pw_b, pm_b, pe_b, pd_b, pf_b}), 32'(e.ph_b));
      check("busy_b",  32'(busy_b), 32'(e.busy_b));
      check("done_b",  32'(done_b), 32'(e.done_b));
      check("count_b", 32'(cnt_b),  32'(e.cnt_b));
    end
  end

  initial begin
    skip_mem[0] = 1; skip_mem[1] = 0;
    where[0] = IDLE; where[1] = IDLE;
    stop_req[0] = 0; stop_req[1] = 0;
    retired[0] = 0; retired[1] = 0;

    repeat (2) drive(1, 1, 0, 0, 0, 0);
    // Single step: Run pulse with Halt held high, memory required.
    drive(0, 1, 1, 1, 0, 1);
    repeat (7) drive(0, 1, 0, 1, 0, 1);
    // Continuous run with memory skipped where allowed.
    repeat (12) drive(0, 1, 1, 0, 0, 0);
    // Halt pulse mid-instruction, then drain.
    drive(0, 1, 1, 1, 0, 0);
    repeat (6) drive(0, 1, 0, 0, 0, 0);
    // Stalls in FETCH and MEMORY.
    drive(0, 1, 1, 1, 1, 1);
    repeat (2) drive(0, 1, 0, 0, 1, 1);
    repeat (3) drive(0, 1, 0, 0, 0, 1);
    repeat (2) drive(0, 1, 0, 0, 1, 1);
    repeat (4) drive(0, 1, 0, 0, 0, 1);
    // ClockEnable low in EXECUTE.
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    repeat (2) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    // Reset while ClockEnable is low mid-instruction.
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    // Long continuous run: wraps the 4-bit counter.
    repeat (100) drive(0, 1, 1, 0, 0, ($urandom_range(0, 1) == 1));
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 1) == 1));
    end
    repeat (2) drive(0, 1, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
